// File: rtl/life_seq_engine.sv
// life_seq_engine: self-sequencing multi-generation cellular automaton on a ping-pong row memory
module life_seq_engine #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 256,
    parameter int DBITS = 8,
    parameter int GBITS = 16,
    parameter int PBITS = 17
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [GBITS-1:0] i_num_gens,
    input  logic             i_wrap_en,
    input  logic [8:0]       i_birth,
    input  logic [8:0]       i_survive,
    input  logic             i_init_we,
    input  logic [DBITS-1:0] i_init_addr,
    input  logic [WIDTH-1:0] i_init_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [GBITS-1:0] o_gen_count,
    output logic [PBITS-1:0] o_pop_count
);
    localparam int KBITS = DBITS + 2;

    typedef enum logic [1:0] {IDLE, PASS, NEXT, DONE} state_t;

    state_t           r_state, w_nstate;
    logic [WIDTH-1:0] r_mem [2*DEPTH];
    logic [WIDTH-1:0] r_mem_q, r_win0, r_win1, r_win2, r_nxt, w_rdata, w_next;
    logic [WIDTH-1:0] w_ul, w_ur, w_ml, w_mr, w_dl, w_dr;
    logic             r_bank, r_wrap, r_rd_pend;
    logic [KBITS-1:0] r_k;
    logic [GBITS-1:0] r_num_gens, r_gen;
    logic [8:0]       r_birth, r_survive;
    logic [PBITS-1:0] r_acc, r_pop, w_pop;
    logic [3:0]       w_n;
    logic             w_idle, w_wr, w_nbusy;
    logic [DBITS-1:0] w_rrow, w_wrow;
    logic [DBITS:0]   w_raddr, w_waddr;

    // Neighbour at column c-1 / c+1; the edge column sees the opposite edge only in toroidal mode
    function automatic logic [WIDTH-1:0] left_of(input logic [WIDTH-1:0] x, input logic wrap);
        return {x[WIDTH-2:0], wrap & x[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] right_of(input logic [WIDTH-1:0] x, input logic wrap);
        return {wrap & x[0], x[WIDTH-1:1]};
    endfunction

    assign w_idle  = r_state == IDLE;
    assign w_wr    = r_state == PASS && r_k >= KBITS'(5);
    assign w_rrow  = DBITS'(r_k - KBITS'(1));
    assign w_wrow  = DBITS'(r_k - KBITS'(5));
    assign w_raddr = {r_bank, w_idle ? i_init_addr : w_rrow};
    assign w_waddr = w_idle ? {r_bank, i_init_addr} : {~r_bank, w_wrow};
    // Rows fetched at k=0 and k=DEPTH+1 lie beyond the board; in dead-edge mode they arrive as zero
    assign w_rdata = (!r_wrap && (r_k == KBITS'(1) || r_k == KBITS'(DEPTH + 2))) ? '0 : r_mem_q;
    assign w_ul    = left_of(r_win2, r_wrap);
    assign w_ur    = right_of(r_win2, r_wrap);
    assign w_ml    = left_of(r_win1, r_wrap);
    assign w_mr    = right_of(r_win1, r_wrap);
    assign w_dl    = left_of(r_win0, r_wrap);
    assign w_dr    = right_of(r_win0, r_wrap);
    assign w_nbusy = w_nstate == PASS || w_nstate == NEXT;
    assign o_gen_count = r_gen;
    assign o_pop_count = r_pop;

    // State register
    always_ff @(posedge i_clk)
        r_state <= !i_reset ? IDLE : w_nstate;

    // Next-state logic
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            IDLE:    w_nstate = i_start ? ((i_num_gens == '0) ? DONE : PASS) : IDLE;
            PASS:    w_nstate = (r_k == KBITS'(DEPTH + 4)) ? NEXT : PASS;
            NEXT:    w_nstate = (GBITS'(r_gen + 1'b1) == r_num_gens) ? DONE : PASS;
            default: w_nstate = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_busy = r_state == PASS || r_state == NEXT;
        o_done = r_state == DONE;
    end

    // Next state of the centre window row from its eight neighbours
    always_comb begin
        w_next = '0;
        w_n    = '0;
        for (int c = 0; c < WIDTH; c++) begin
            w_n = 4'(w_ul[c]) + 4'(r_win2[c]) + 4'(w_ur[c]) + 4'(w_ml[c]) + 4'(w_mr[c])
                + 4'(w_dl[c]) + 4'(r_win0[c]) + 4'(w_dr[c]);
            w_next[c] = r_win1[c] ? r_survive[w_n] : r_birth[w_n];
        end
    end

    // Live cells in the row about to be written
    always_comb begin
        w_pop = '0;
        for (int c = 0; c < WIDTH; c++) w_pop = w_pop + PBITS'(r_nxt[c]);
    end

    // Row memory: host writes in IDLE, engine writes the other bank during a pass
    always_ff @(posedge i_clk) begin
        if ((w_idle && i_init_we) || w_wr) r_mem[w_waddr] <= w_idle ? i_init_data : r_nxt;
        r_mem_q <= r_mem[w_raddr];
    end

    // Three-row sliding window and registered next-row result
    always_ff @(posedge i_clk) begin
        r_win2 <= r_win1;
        r_win1 <= r_win0;
        r_win0 <= w_rdata;
        r_nxt  <= w_next;
    end

    // Run control, counters and host readback pipeline
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_bank     <= 1'b0;
            r_k        <= '0;
            r_gen      <= '0;
            r_pop      <= '0;
            r_acc      <= '0;
            r_rd_pend  <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
            r_num_gens <= '0;
            r_wrap     <= 1'b0;
            r_birth    <= '0;
            r_survive  <= '0;
        end else begin
            r_rd_pend  <= w_idle && i_rd_en;
            o_rd_valid <= r_rd_pend && !w_nbusy;
            if (r_rd_pend) o_rd_data <= r_mem_q;
            if (w_idle && i_start) begin
                r_num_gens <= i_num_gens;
                r_wrap     <= i_wrap_en;
                r_birth    <= i_birth;
                r_survive  <= i_survive;
                r_gen      <= '0;
                r_acc      <= '0;
                r_k        <= '0;
            end
            if (r_state == PASS) begin
                r_k <= r_k + 1'b1;
                if (w_wr) r_acc <= r_acc + w_pop;
            end
            if (r_state == NEXT) begin
                r_bank <= ~r_bank;
                r_gen  <= r_gen + 1'b1;
                r_pop  <= r_acc;
                r_acc  <= '0;
                r_k    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_life_seq_engine.sv
// tb_life_seq_engine: table, random and corner-case checks of life_seq_engine on an 8x8 board
module tb_life_seq_engine;
    localparam int W = 8, D = 8, DB = 3, GB = 16, PB = 7;
    localparam logic [63:0] BH   = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BV   = 64'h0000_0008_0808_0000;
    localparam logic [63:0] GLD  = 64'h0000_0000_0007_0402;
    localparam logic [63:0] DOT  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] RING = 64'h0000_001C_141C_0000;

    logic          clk = 1'b0;
    logic          i_reset, i_start, i_wrap_en, i_init_we, i_rd_en;
    logic [GB-1:0] i_num_gens;
    logic [8:0]    i_birth, i_survive;
    logic [DB-1:0] i_init_addr;
    logic [W-1:0]  i_init_data, o_rd_data;
    logic          o_rd_valid, o_busy, o_done;
    logic [GB-1:0] o_gen_count;
    logic [PB-1:0] o_pop_count;

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    life_seq_engine #(.WIDTH(W), .DEPTH(D), .DBITS(DB), .GBITS(GB), .PBITS(PB)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_num_gens(i_num_gens),
        .i_wrap_en(i_wrap_en), .i_birth(i_birth), .i_survive(i_survive),
        .i_init_we(i_init_we), .i_init_addr(i_init_addr), .i_init_data(i_init_data),
        .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_busy(o_busy), .o_done(o_done), .o_gen_count(o_gen_count), .o_pop_count(o_pop_count)
    );

    typedef struct {
        logic [63:0]   init;
        logic [GB-1:0] gens;
        bit            wrap;
        logic [8:0]    bi;
        logic [8:0]    su;
        logic [63:0]   exp;
        bit            has_exp;
        int            pop;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: Life-like rule on a bounded or toroidal 8x8 grid, cell (r,c) = bit r*8+c
    function automatic logic [63:0] life_step(input logic [63:0] b, input bit wrap,
                                              input logic [8:0] bi, input logic [8:0] su);
        logic [63:0] nb;
        int n, rr, cc;
        nb = '0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap) begin
                                rr = (rr + D) % D;
                                cc = (cc + W) % W;
                            end
                            if (rr >= 0 && rr < D && cc >= 0 && cc < W) n += int'(b[rr*W+cc]);
                        end
                nb[r*W+c] = b[r*W+c] ? su[n] : bi[n];
            end
        return nb;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] b, input int gens, input bit wrap,
                                          input logic [8:0] bi, input logic [8:0] su);
        logic [63:0] x;
        x = b;
        for (int g = 0; g < gens; g++) x = life_step(x, wrap, bi, su);
        return x;
    endfunction

    task automatic load_board(input logic [63:0] b);
        for (int r = 0; r < D; r++) begin
            i_init_we   = 1'b1;
            i_init_addr = DB'(r);
            i_init_data = b[r*W+:W];
            tick();
        end
        i_init_we = 1'b0;
    endtask

    task automatic read_board(output logic [63:0] b, output bit all_valid);
        all_valid = 1'b1;
        for (int r = 0; r < D; r++) begin
            i_rd_en     = 1'b1;
            i_init_addr = DB'(r);
            tick();
            i_rd_en = 1'b0;
            tick();
            b[r*W+:W] = o_rd_data;
            all_valid &= o_rd_valid;
        end
    endtask

    // Start a run, then scramble the sampled controls to show they are held
    task automatic run(input logic [GB-1:0] g, input bit wrap, input logic [8:0] bi,
                       input logic [8:0] su, output int cyc);
        i_num_gens = g;
        i_wrap_en  = wrap;
        i_birth    = bi;
        i_survive  = su;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        i_num_gens = GB'($urandom);
        i_wrap_en  = ~wrap;
        i_birth    = 9'($urandom);
        i_survive  = 9'($urandom);
        cyc = 1;
        while (!o_done && cyc < 5000) begin
            tick();
            cyc++;
        end
    endtask

    vec_t        vecs[6];
    logic [63:0] got, exp_b, prev;
    bit          vld, saw;
    int          cyc, g;
    logic [8:0]  bi, su;
    bit          wr;

    initial begin
        vecs[0] = '{BH,   16'd1,  1'b0, 9'h008, 9'h00C, BV,   1'b1, 3};
        vecs[1] = '{BH,   16'd2,  1'b1, 9'h008, 9'h00C, BH,   1'b1, 3};
        vecs[2] = '{GLD,  16'd32, 1'b1, 9'h008, 9'h00C, GLD,  1'b1, 5};
        vecs[3] = '{GLD,  16'd32, 1'b0, 9'h008, 9'h00C, '0,   1'b0, 4};
        vecs[4] = '{DOT,  16'd1,  1'b0, 9'h002, 9'h000, RING, 1'b1, 8};
        vecs[5] = '{BH,   16'd3,  1'b1, 9'h008, 9'h00C, BV,   1'b1, 3};

        i_reset = 1'b0; i_start = 1'b0; i_wrap_en = 1'b0; i_init_we = 1'b0; i_rd_en = 1'b0;
        i_num_gens = '0; i_birth = 9'h008; i_survive = 9'h00C; i_init_addr = '0; i_init_data = '0;
        tick();
        tick();
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_rd_valid", 64'(o_rd_valid), 64'd0);
        check("reset_rd_data", 64'(o_rd_data), 64'd0);
        check("reset_gen", 64'(o_gen_count), 64'd0);
        check("reset_pop", 64'(o_pop_count), 64'd0);
        i_reset = 1'b1;
        tick();

        // Readback latency: valid exactly two cycles after the request
        load_board(BH);
        i_rd_en = 1'b1;
        i_init_addr = 3'd3;
        tick();
        i_rd_en = 1'b0;
        check("rd_lat1_valid", 64'(o_rd_valid), 64'd0);
        tick();
        check("rd_lat2_valid", 64'(o_rd_valid), 64'd1);
        check("rd_lat2_data", 64'(o_rd_data), 64'h1C);
        tick();
        check("rd_lat3_valid", 64'(o_rd_valid), 64'd0);

        foreach (vecs[i]) begin
            load_board(vecs[i].init);
            run(vecs[i].gens, vecs[i].wrap, vecs[i].bi, vecs[i].su, cyc);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(int'(vecs[i].gens) * (D + 6) + 1));
            check($sformatf("vec%0d_busy_at_done", i), 64'(o_busy), 64'd0);
            check($sformatf("vec%0d_gen", i), 64'(o_gen_count), 64'(vecs[i].gens));
            check($sformatf("vec%0d_pop", i), 64'(o_pop_count), 64'(vecs[i].pop));
            tick();
            read_board(got, vld);
            exp_b = vecs[i].has_exp ? vecs[i].exp
                  : model(vecs[i].init, int'(vecs[i].gens), vecs[i].wrap, vecs[i].bi, vecs[i].su);
            check($sformatf("vec%0d_valid", i), 64'(vld), 64'd1);
            check($sformatf("vec%0d_board", i), got, exp_b);
        end

        for (int t = 0; t < 8; t++) begin
            prev = {$urandom, $urandom};
            g    = int'($urandom_range(1, 4));
            wr   = 1'($urandom);
            bi   = t[0] ? 9'($urandom) : 9'h008;
            su   = t[0] ? 9'($urandom) : 9'h00C;
            exp_b = model(prev, g, wr, bi, su);
            load_board(prev);
            run(GB'(g), wr, bi, su, cyc);
            check($sformatf("rnd%0d_cycles", t), 64'(cyc), 64'(g * (D + 6) + 1));
            check($sformatf("rnd%0d_gen", t), 64'(o_gen_count), 64'(g));
            check($sformatf("rnd%0d_pop", t), 64'(o_pop_count), 64'($countones(exp_b)));
            tick();
            read_board(got, vld);
            check($sformatf("rnd%0d_board", t), got, exp_b);
        end

        // Zero generations: immediate done, counter cleared, board untouched
        prev = exp_b;
        run(16'd0, 1'b1, 9'h008, 9'h00C, cyc);
        check("zero_cycles", 64'(cyc), 64'd1);
        check("zero_gen", 64'(o_gen_count), 64'd0);
        check("zero_busy", 64'(o_busy), 64'd0);
        tick();
        read_board(got, vld);
        check("zero_board", got, prev);

        // Start, host write and host read during a run are all ignored
        load_board(BH);
        i_num_gens = 16'd3; i_wrap_en = 1'b1; i_birth = 9'h008; i_survive = 9'h00C;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 1;
        saw = 1'b0;
        while (!o_done && cyc < 5000) begin
            i_start     = cyc == 5;
            i_num_gens  = 16'd1;
            i_init_we   = cyc == 10;
            i_init_addr = (cyc == 10) ? 3'd0 : 3'd3;
            i_init_data = 8'hFF;
            i_rd_en     = cyc == 20;
            tick();
            cyc++;
            saw |= o_rd_valid;
        end
        i_start = 1'b0; i_init_we = 1'b0; i_rd_en = 1'b0;
        check("midrun_cycles", 64'(cyc), 64'(3 * (D + 6) + 1));
        check("midrun_rd_valid", 64'(saw), 64'd0);
        check("midrun_gen", 64'(o_gen_count), 64'd3);
        check("midrun_pop", 64'(o_pop_count), 64'd3);
        tick();
        read_board(got, vld);
        check("midrun_board", got, model(BH, 3, 1'b1, 9'h008, 9'h00C));

        // Reset during the second pass
        load_board(GLD);
        i_num_gens = 16'd3; i_wrap_en = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (19) tick();
        check("pre_reset_busy", 64'(o_busy), 64'd1);
        i_reset = 1'b0;
        tick();
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_gen", 64'(o_gen_count), 64'd0);
        check("rst_pop", 64'(o_pop_count), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        i_reset = 1'b1;
        saw = 1'b0;
        repeat (60) begin
            tick();
            saw |= o_done | o_busy;
        end
        check("rst_no_done", 64'(saw), 64'd0);
        load_board(BH);
        run(16'd1, 1'b0, 9'h008, 9'h00C, cyc);
        check("rst_rerun_cycles", 64'(cyc), 64'(D + 7));
        check("rst_rerun_pop", 64'(o_pop_count), 64'd3);
        tick();
        read_board(got, vld);
        check("rst_rerun_board", got, BV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
